// File: rtl/dsp_fe_snapshot.sv
// Trigger-armed circular capture buffer for frontend frames.
// Freezes after a programmable post-trigger count; readback is oldest-first.
module dsp_fe_snapshot #(
  parameter int unsigned LANE_WIDTH    = 16,
  parameter int unsigned DES_OUT_WIDTH = 4,
  parameter int unsigned ADC_WIDTH     = 6,
  parameter int unsigned DEPTH         = 16
) (
  input  logic                                                   i_clk,
  input  logic                                                   i_rstb,
  input  logic [LANE_WIDTH*DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0]     i_dat_fe,
  input  logic                                                   i_arm,
  input  logic                                                   i_abort,
  input  logic [1:0]                                             i_trig_mode,
  input  logic                                                   i_ext_trig,
  input  logic [ADC_WIDTH-1:0]                                   i_thresh,
  input  logic [$clog2(DEPTH)-1:0]                               i_post_cnt,
  input  logic [$clog2(DEPTH)-1:0]                               i_rd_addr,
  output logic [LANE_WIDTH*DES_OUT_WIDTH-1:0][ADC_WIDTH-1:0]     o_rd_dat,
  output logic [1:0]                                             o_state,
  output logic                                                   o_done,
  output logic [$clog2(DEPTH):0]                                 o_nvalid,
  output logic [$clog2(DEPTH)-1:0]                               o_trig_ptr,
  output logic [$clog2(LANE_WIDTH*DES_OUT_WIDTH)-1:0]            o_trig_idx
);

  localparam int unsigned FRAME = LANE_WIDTH * DES_OUT_WIDTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SW    = $clog2(FRAME);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [FRAME-1:0][ADC_WIDTH-1:0] mem [DEPTH];
  logic [FRAME-1:0][ADC_WIDTH-1:0] dat_q;
  logic                            ext_q;
  logic [1:0]                      state, state_n;
  logic [AW-1:0]                   wr_ptr, wr_ptr_n;
  logic [AW:0]                     nvalid_n;
  logic [AW-1:0]                   cnt, cnt_n;
  logic [1:0]                      mode_q, mode_n;
  logic [ADC_WIDTH-1:0]            thresh_q, thresh_n;
  logic [AW-1:0]                   post_q, post_n;
  logic [AW-1:0]                   trig_phys, trig_phys_n;
  logic [SW-1:0]                   trig_idx_n;
  logic [AW-1:0]                   trig_ptr_n;
  logic [AW-1:0]                   oldest_n;
  logic [AW-1:0]                   oldest_c;
  logic [AW-1:0]                   rd_phys_c;
  logic                            we_c;
  logic                            thr_hit_c;
  logic [SW-1:0]                   thr_idx_c;
  logic                            trig_c;

  assign o_state = state;

  // Lowest sample index meeting the threshold (scan high to low so low wins).
  always_comb begin
    thr_hit_c = 1'b0;
    thr_idx_c = '0;
    for (int i = FRAME - 1; i >= 0; i--) begin
      if (dat_q[i] >= thresh_q) begin
        thr_hit_c = 1'b1;
        thr_idx_c = SW'(i);
      end
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    trig_c = 1'b1;
      2'd1:    trig_c = ext_q;
      2'd2:    trig_c = thr_hit_c;
      default: trig_c = 1'b0;
    endcase
  end

  // Next-state and capture bookkeeping.
  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    nvalid_n    = o_nvalid;
    cnt_n       = cnt;
    mode_n      = mode_q;
    thresh_n    = thresh_q;
    post_n      = post_q;
    trig_phys_n = trig_phys;
    trig_idx_n  = o_trig_idx;
    we_c        = 1'b0;
    if (i_abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            state_n  = S_ARMED;
            wr_ptr_n = '0;
            nvalid_n = '0;
            cnt_n    = '0;
            mode_n   = i_trig_mode;
            thresh_n = i_thresh;
            post_n   = i_post_cnt;
          end
        end
        S_ARMED: begin
          we_c     = 1'b1;
          wr_ptr_n = wr_ptr + AW'(1);
          nvalid_n = (o_nvalid == FULL) ? o_nvalid : o_nvalid + (AW+1)'(1);
          if (trig_c) begin
            trig_phys_n = wr_ptr;
            trig_idx_n  = (mode_q == 2'd2) ? thr_idx_c : '0;
            if (post_q == '0) begin
              state_n = S_DONE;
            end else begin
              cnt_n   = post_q;
              state_n = S_POST;
            end
          end
        end
        default: begin
          we_c     = 1'b1;
          wr_ptr_n = wr_ptr + AW'(1);
          nvalid_n = (o_nvalid == FULL) ? o_nvalid : o_nvalid + (AW+1)'(1);
          cnt_n    = cnt - AW'(1);
          if (cnt == AW'(1)) state_n = S_DONE;
        end
      endcase
    end
    oldest_n   = (nvalid_n == FULL) ? wr_ptr_n : '0;
    trig_ptr_n = trig_phys_n - oldest_n;
  end

  assign oldest_c  = (o_nvalid == FULL) ? wr_ptr : '0;
  assign rd_phys_c = oldest_c + i_rd_addr;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state      <= S_IDLE;
      dat_q      <= '0;
      ext_q      <= 1'b0;
      wr_ptr     <= '0;
      o_nvalid   <= '0;
      cnt        <= '0;
      mode_q     <= '0;
      thresh_q   <= '0;
      post_q     <= '0;
      trig_phys  <= '0;
      o_trig_idx <= '0;
      o_trig_ptr <= '0;
      o_done     <= 1'b0;
      o_rd_dat   <= '0;
    end else begin
      state      <= state_n;
      dat_q      <= i_dat_fe;
      ext_q      <= i_ext_trig;
      wr_ptr     <= wr_ptr_n;
      o_nvalid   <= nvalid_n;
      cnt        <= cnt_n;
      mode_q     <= mode_n;
      thresh_q   <= thresh_n;
      post_q     <= post_n;
      trig_phys  <= trig_phys_n;
      o_trig_idx <= trig_idx_n;
      o_trig_ptr <= trig_ptr_n;
      o_done     <= (state_n == S_DONE);
      o_rd_dat   <= mem[rd_phys_c];
    end
  end

  // Frame memory carries no reset.
  always_ff @(posedge i_clk) begin
    if (we_c) mem[wr_ptr] <= dat_q;
  end

endmodule
